// File: rtl/tinyalu_pkg.sv
// Shared types for the tinyalu initiator: ALU operation codes and FSM states.
// Also holds the op-code helpers used by the initiator.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    // Ops that wait for alu_done; everything else completes after one start cycle.
    function automatic logic needs_done(input logic [2:0] code);
        return (code == add_op) || (code == and_op) ||
               (code == xor_op) || (code == mul_op);
    endfunction

    // Undefined codes (101/110) are presented to the ALU as no_op.
    function automatic operation_t alu_op_of(input logic [2:0] code);
        if (code == 3'b101 || code == 3'b110)
            return no_op;
        return operation_t'(code);
    endfunction

endpackage

// File: rtl/tinyalu_watchdog.sv
// Cycle counter bounding how long alu_start may wait for alu_done.
// expired is high during the TIMEOUT-th consecutive enabled cycle.
module tinyalu_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] count;

    assign expired = enable && (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && !expired)
            count <= count + CW'(1);
    end

endmodule

// File: rtl/tinyalu_initiator.sv
// Command/response wrapper around the tinyalu start/done port: accepts one
// command, runs it on the ALU (with watchdog), and holds the response until consumed.
module tinyalu_initiator
    import tinyalu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        rsp_timeout,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        alu_reset_n,
    output logic        busy
);

    state_t      state, state_nxt;
    logic [15:0] result_q, result_nxt;
    logic        timeout_q, timeout_nxt;
    logic [2:0]  op_q;
    logic [7:0]  a_q, b_q;
    operation_t  alu_op_q;
    logic        accept;
    logic        wd_expired;

    tinyalu_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != BUSY),
        .enable (state == BUSY),
        .expired(wd_expired)
    );

    always_comb begin
        state_nxt   = state;
        result_nxt  = result_q;
        timeout_nxt = timeout_q;
        cmd_ready   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !reset;
                if (cmd_valid)
                    state_nxt = BUSY;
            end
            BUSY: begin
                // alu_done is checked before the watchdog so it wins a tie.
                if (!needs_done(op_q)) begin
                    state_nxt   = RESP;
                    result_nxt  = '0;
                    timeout_nxt = 1'b0;
                end else if (alu_done) begin
                    state_nxt   = RESP;
                    result_nxt  = alu_result;
                    timeout_nxt = 1'b0;
                end else if (wd_expired) begin
                    state_nxt   = RESP;
                    result_nxt  = '0;
                    timeout_nxt = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            result_q  <= '0;
            timeout_q <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_op_q  <= no_op;
        end else begin
            state     <= state_nxt;
            result_q  <= result_nxt;
            timeout_q <= timeout_nxt;
            if (accept) begin
                a_q      <= cmd_a;
                b_q      <= cmd_b;
                op_q     <= cmd_op;
                alu_op_q <= alu_op_of(cmd_op);
            end
        end
    end

    assign alu_start   = (state == BUSY);
    assign rsp_valid   = (state == RESP);
    assign busy        = (state != IDLE);
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = alu_op_q;
    assign rsp_op      = op_q;
    assign rsp_result  = result_q;
    assign rsp_timeout = timeout_q;
    assign alu_reset_n = !reset;

endmodule

// File: tb/tb_tinyalu_initiator.sv
// Self-checking bench for tinyalu_initiator: an ALU responder with programmable
// latency, a command-level reference model, directed cases and a random loop.
`timescale 1ns/1ps
module tb_tinyalu_initiator;
    import tinyalu_pkg::*;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_a, cmd_b;
    logic [2:0]  cmd_op;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_timeout;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        alu_start, alu_done;
    logic [15:0] alu_result;
    logic        alu_reset_n, busy;

    logic        model_done, spur_done;
    int          model_cnt;
    int          alu_lat;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    assign alu_done = model_done | spur_done;

    always #5 clk = ~clk;

    tinyalu_initiator #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_timeout(rsp_timeout),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result),
        .alu_reset_n(alu_reset_n), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ALU stand-in: done pulses alu_lat cycles into a start burst (alu_lat=0: never).
    function automatic logic [15:0] alu_calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return 16'(a) * 16'(b);
            default: return 16'hDEAD;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_done <= 1'b0;
            model_cnt  <= 0;
            alu_result <= '0;
        end else if (!alu_start || model_done) begin
            model_done <= 1'b0;
            model_cnt  <= 0;
        end else if (alu_lat != 0 && model_cnt + 1 == alu_lat) begin
            model_done <= 1'b1;
            alu_result <= alu_calc(alu_op, alu_a, alu_b);
        end else begin
            model_cnt <= model_cnt + 1;
        end
    end

    // alu_start must stay low at least two cycles between bursts.
    int low_run = 0;
    bit seen_start = 0;
    bit prev_start = 0;
    always @(negedge clk) begin
        if (alu_start && !prev_start && seen_start)
            check("start_gap_ge2", 32'(low_run >= 2), 32'd1);
        if (alu_start) seen_start = 1;
        low_run = alu_start ? 0 : ((low_run < 1000) ? low_run + 1 : low_run);
        prev_start = alu_start;
    end

    // Reference model: what the command should produce given the ALU latency.
    task automatic predict(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input int lat, output logic [15:0] res, output logic to,
                           output int starts);
        int unsigned ua, ub;
        ua = a;
        ub = b;
        to = 1'b0;
        case (op)
            3'd1: res = 16'(ua + ub);
            3'd2: res = 16'(ua & ub);
            3'd3: res = 16'(ua ^ ub);
            3'd4: res = 16'(ua * ub);
            default: res = 16'h0000;
        endcase
        if (op == 3'd1 || op == 3'd2 || op == 3'd3 || op == 3'd4) begin
            if (lat != 0 && lat + 1 <= int'(TIMEOUT)) begin
                starts = lat + 1;
            end else begin
                starts = TIMEOUT;
                res    = 16'h0000;
                to     = 1'b1;
            end
        end else begin
            starts = 1;
        end
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int lat, input int rdy_wait, input bit junk_valid);
        logic [15:0] er;
        logic        eto;
        int          es;
        int          starts = 0;
        int          cyc = 0;
        bit          ready_bad = 0;
        bit          opnd_bad = 0;
        bit          single;
        logic [2:0]  exp_alu_op;
        predict(op, a, b, lat, er, eto, es);
        single = !(op == 3'd1 || op == 3'd2 || op == 3'd3 || op == 3'd4);
        exp_alu_op = (op == 3'b101 || op == 3'b110) ? 3'b000 : op;
        alu_lat = lat;
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
        @(negedge clk);
        if (junk_valid) begin
            cmd_a = ~a; cmd_b = ~b; cmd_op = 3'b001;
        end else begin
            cmd_valid = 1'b0;
        end
        check("busy_after_accept", 32'(busy), 32'd1);
        spur_done = single;
        while (!rsp_valid && cyc < 200) begin
            if (alu_start) starts++;
            if (cmd_ready) ready_bad = 1;
            if (alu_a !== a || alu_b !== b || alu_op !== exp_alu_op) opnd_bad = 1;
            @(negedge clk);
            spur_done = 1'b0;
            cyc++;
        end
        check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
        check("start_cycles", 32'(starts), 32'(es));
        check("cmd_ready_low_busy", 32'(ready_bad), 32'd0);
        check("alu_operands_stable", 32'(opnd_bad), 32'd0);
        check("rsp_result", 32'(rsp_result), 32'(er));
        check("rsp_op", 32'(rsp_op), 32'(op));
        check("rsp_timeout", 32'(rsp_timeout), 32'(eto));
        check("start_low_resp", 32'(alu_start), 32'd0);
        for (int i = 0; i < rdy_wait; i++) begin
            spur_done = i[0];
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_result", 32'(rsp_result), 32'(er));
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        spur_done = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("cmd_ready_after", 32'(cmd_ready), 32'd1);
        if (junk_valid)
            check("no_cmd_queuing", {16'(alu_a), 16'(alu_b)}, {16'(a), 16'(b)});
    endtask

    initial begin
        #300000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
        rsp_ready = 1'b0; spur_done = 1'b0; alu_lat = 1;
        @(negedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_alu_start", 32'(alu_start), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_fields", {16'(rsp_result), 8'(rsp_op), 8'(rsp_timeout)}, 32'd0);
        check("rst_alu_fields", {8'(alu_a), 8'(alu_b), 8'(alu_op), 8'(busy)}, 32'd0);
        check("rst_alu_reset_n", 32'(alu_reset_n), 32'd0);
        reset = 1'b0;
        #1;
        check("alu_reset_n_release", 32'(alu_reset_n), 32'd1);

        do_cmd(3'b001, 8'hFF, 8'h01, 1, 0, 0);   // add -> 0100
        do_cmd(3'b100, 8'hFF, 8'hFF, 3, 0, 0);   // mul, 3-cycle latency -> FE01
        do_cmd(3'b000, 8'hA5, 8'h0F, 1, 0, 0);   // no_op -> 0
        do_cmd(3'b011, 8'hA5, 8'h0F, 1, 0, 0);   // xor -> 00AA
        do_cmd(3'b010, 8'h12, 8'h34, 0, 0, 0);   // stubbed done: timeout after 16
        do_cmd(3'b001, 8'h10, 8'h20, 15, 0, 0);  // done on the timeout cycle wins
        do_cmd(3'b001, 8'h10, 8'h20, 16, 0, 0);  // done one cycle too late
        do_cmd(3'b010, 8'hF0, 8'h3C, 1, 10, 1);  // long rsp_ready hold -> 0030
        do_cmd(3'b101, 8'h11, 8'h22, 1, 1, 0);
        do_cmd(3'b110, 8'h33, 8'h44, 1, 0, 0);
        do_cmd(3'b111, 8'h55, 8'h66, 1, 0, 0);

        // Stray alu_done while idle must not start anything.
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        spur_done = 1'b0;
        check("stray_done_busy", 32'(busy), 32'd0);
        check("stray_done_rsp", 32'(rsp_valid), 32'd0);

        // Reset in the middle of a mul.
        alu_lat = 3;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_a = 8'h07; cmd_b = 8'h09; cmd_op = 3'b100;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(alu_start), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_start", 32'(alu_start), 32'd0);
        check("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd0);
        check("mid_rst_alu_op", 32'(alu_op), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        do_cmd(3'b001, 8'h02, 8'h03, 1, 0, 0);   // -> 0005

        for (int n = 0; n < 24; n++) begin
            logic [2:0] op;
            logic [7:0] a, b;
            int lat;
            op  = 3'($urandom_range(0, 7));
            a   = 8'($urandom);
            b   = 8'($urandom);
            lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
            do_cmd(op, a, b, lat, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
